maxpool_1d_stream: RTL



---
 rtl/maxpool_1d_stream.sv | 86 ++++++++
 1 files changed

// File: rtl/maxpool_1d_stream.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_1d_stream
// Brief    : Streaming 1-D max pooling over non-overlapping windows of POOL
//            samples, windows closed early at each LEN-sample vector boundary.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_1d_stream #(
  parameter int WIDTH  = 11,
  parameter int LEN    = 22,
  parameter int POOL   = 2,
  parameter int LOGLEN = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  output logic [WIDTH-1:0] m_data_out_z,
  output logic             m_valid_z,
  input  logic             m_ready_z
);

  localparam logic [LOGLEN-1:0] c_pool_last = LOGLEN'(POOL - 1);
  localparam logic [LOGLEN-1:0] c_len_last  = LOGLEN'(LEN - 1);
  localparam logic [LOGLEN-1:0] c_one       = LOGLEN'(1);

  logic [LOGLEN-1:0] r_wcnt;
  logic [LOGLEN-1:0] r_ecnt;
  logic [WIDTH-1:0]  r_run_max;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_valid_out;

  logic              w_close;
  logic              w_ready;
  logic              w_accept;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_cand;

  always_comb begin
    w_close = (r_wcnt == c_pool_last) || (r_ecnt == c_len_last);
    // Only a closing sample needs the output slot, so only it can stall.
    w_ready  = ~reset & ~(r_valid_out & ~m_ready_z & w_close);
    w_accept = s_valid_y & w_ready;
    w_xfer   = r_valid_out & m_ready_z;
    if (r_wcnt == '0) begin
      w_cand = s_data_in_y;
    end else if ($signed(r_run_max) > $signed(s_data_in_y)) begin
      w_cand = r_run_max;
    end else begin
      w_cand = s_data_in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt      <= '0;
      r_ecnt      <= '0;
      r_run_max   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (w_accept && w_close) begin
        r_data_out  <= w_cand;
        r_valid_out <= 1'b1;
        r_wcnt      <= '0;
        r_ecnt      <= (r_ecnt == c_len_last) ? '0 : r_ecnt + c_one;
      end else begin
        if (w_accept) begin
          r_run_max <= w_cand;
          r_wcnt    <= r_wcnt + c_one;
          r_ecnt    <= r_ecnt + c_one;
        end
        if (w_xfer) begin
          r_valid_out <= 1'b0;
        end
      end
    end
  end

  assign s_ready_y    = w_ready;
  assign m_data_out_z = r_data_out;
  assign m_valid_z    = r_valid_out;

endmodule
`default_nettype wire
